way_age_updater: RTL and testbench
==================================

// Module: way_age_updater
// PURPOSE
//  Write side of the per-way age vector consumed by select_biggest in the replacement path.
//  Keeps one age counter and one valid bit per way, and updates them on hit/fill/invalidate.
//  Supports a multi-cycle flush sweep.
//  way_age_flatted_out feeds select_biggest.way_flatted_in; way_valid_out feeds condition_in.
// PARAMETERS
//  SINGLE_WAY_WIDTH_IN_BITS  4   width of each way's age counter
//  NUM_WAY                   16  number of ways; must be >= 2
//  WAY_INDEX_WIDTH  $clog2(NUM_WAY)  way index width; derived, not overridden
// PORTS
//  clk_in               in   1     clock
//  reset_in             in   1     synchronous reset, active-low
//  access_valid_in      in   1     access request valid
//  access_op_in         in   2     operation: 00 HIT, 01 FILL, 10 INVALIDATE, 11 reserved (NOP)
//  access_way_in        in   WAY_INDEX_WIDTH   target way
//  access_ready_out     out  1     request accepted when valid_in && ready_out
//  flush_in             in   1     single-cycle pulse that starts the flush sweep
//  busy_out             out  1     high while a flush is in progress
//  way_age_flatted_out  out  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY   way i age at [i*W +: W]
//  way_valid_out        out  NUM_WAY   way valid mask
// BEHAVIOUR
//  Reset (reset_in==0 at clk edge): all ages 0, all valid 0, state IDLE, busy_out 0.
//   Mid-flush reset aborts the sweep with the same result.
//  FSM IDLE/FLUSH:
//   IDLE -> FLUSH on flush_in; sweep pointer set to 0.
//   FLUSH: each cycle clears age[ptr] and valid[ptr], then increments ptr.
//   FLUSH -> IDLE after way NUM_WAY-1 is cleared. Sweep takes exactly NUM_WAY cycles.
//  access_ready_out = (state==IDLE) && !flush_in. busy_out = (state==FLUSH). Both are combinational from state.
//  flush_in in the same cycle as access_valid_in: flush wins, the access is not accepted.
//  flush_in while in FLUSH is ignored.
//  Accepted op updates are registered; new values are visible on the outputs the next cycle (1-cycle latency).
//  HIT on way k:
//   - age[k] <= 0.
//   - Every other way j with valid[j]==1 gets age[j] <= age[j]+1, saturating at 2^W-1.
//   - valid is unchanged. HIT on an invalid way still performs the aging.
//  FILL on way k:
//   - valid[k] <= 1 and age[k] <= 0.
//   - Every other valid way is aged with the same saturation rule.
//  INVALIDATE on way k: valid[k] <= 0, age[k] <= 0; no other way changes.
//  Reserved op (11), or access_way_in >= NUM_WAY: handshake still completes, state is unchanged.
//  Invalid ways never age. Counters never wrap.
//  Outputs are driven directly from registers; no combinational path from inputs to the age/valid outputs.
// STRUCTURE
//  Shared package/header (parameters.h) holds:
//   - op encodings AGE_OP_HIT/FILL/INVALIDATE/NOP
//   - FSM state encodings AGE_STATE_IDLE/FLUSH
//  Sub-module age_counter_cell, one instance per way, generated:
//   - inputs: clear, inc, valid
//   - output: a W-bit register with saturating increment
//  Top level holds the FSM, the sweep pointer, and way decode.
// TESTING (W=4, NUM_WAY=16; reset first, ages shown as way15..way0)
//  1 Reset -> all ages 0, valid 16'h0000, ready 1, busy 0.
//  2 FILL ways 0,1,2 back-to-back -> ages way2..0 = 0,1,2; valid 16'h0007.
//    Then select_biggest (condition = valid) returns 4'h2.
//  3 After 2: HIT way 0 -> ages way2..0 = 1,2,0. HIT way 5 (invalid) -> 2,3,1; valid unchanged.
//  4 Saturation: FILL way 0, then 20 HITs on way 1 -> age[0]==4'hf, age[1]==0, no wrap.
//  5 INVALIDATE way 1 after 3 -> valid 16'h0005, age[1]==0, others unchanged. Out-of-range/op 11 -> no change.
//  6 Flush with all ways valid:
//    - flush_in with access_valid_in in the same cycle -> access not accepted.
//    - busy 16 cycles, ready 0; then valid 16'h0000, ages 0.
//    - Reset asserted at sweep cycle 5 -> IDLE next cycle, all cleared.

Source files
------------

// File: rtl/way_age_updater_pkg.sv
// Shared encodings for the per-way age vector writer.
// Holds the access operation codes and the flush FSM state codes.
// Imported by the top level and the per-way counter cell.
package way_age_updater_pkg;

    // Access operation encodings carried on access_op_in.
    typedef enum logic [1:0] {
        AGE_OP_HIT        = 2'b00,
        AGE_OP_FILL       = 2'b01,
        AGE_OP_INVALIDATE = 2'b10,
        AGE_OP_NOP        = 2'b11
    } age_op_e;

    // Flush sweep FSM states.
    typedef enum logic {
        AGE_STATE_IDLE  = 1'b0,
        AGE_STATE_FLUSH = 1'b1
    } age_state_e;

endpackage

// File: rtl/way_age_updater_age_counter_cell.sv
// One way's age counter: clears to zero or increments with saturation.
// Latency: 1 cycle from clear/inc to the registered age output.
// Backpressure: none; clear has priority over increment, invalid ways never age.
module age_counter_cell #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         clear_in,
    input  logic         inc_in,
    input  logic         valid_in,
    output logic [W-1:0] age_out
);

    logic [W-1:0] age_q;
    logic [W-1:0] age_d;

    // Next age: clear wins, otherwise a saturating increment on valid ways only.
    always_comb begin
        age_d = age_q;
        if (clear_in) begin
            age_d = '0;
        end else if (inc_in && valid_in && (age_q != {W{1'b1}})) begin
            age_d = age_q + W'(1);
        end
    end

    // Age register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_out = age_q;

endmodule

// File: rtl/way_age_updater.sv
// Per-way age/valid writer for the replacement path, with a one-way-per-cycle flush sweep.
// Latency: accepted ops are visible on the outputs 1 cycle later; a flush takes NUM_WAY cycles.
// Backpressure: access_ready_out drops while flushing or when flush_in is raised.
module way_age_updater
    import way_age_updater_pkg::*;
#(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int NUM_WAY                  = 16,
    parameter int WAY_INDEX_WIDTH          = $clog2(NUM_WAY)
) (
    input  logic                                    clk_in,
    input  logic                                    reset_in,
    input  logic                                    access_valid_in,
    input  logic [1:0]                              access_op_in,
    input  logic [WAY_INDEX_WIDTH-1:0]              access_way_in,
    output logic                                    access_ready_out,
    input  logic                                    flush_in,
    output logic                                    busy_out,
    output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_age_flatted_out,
    output logic [NUM_WAY-1:0]                      way_valid_out
);

    localparam int W = SINGLE_WAY_WIDTH_IN_BITS;

    age_state_e                 state_q;
    age_state_e                 state_d;
    logic [WAY_INDEX_WIDTH-1:0] ptr_q;
    logic [WAY_INDEX_WIDTH-1:0] ptr_d;
    logic [NUM_WAY-1:0]         valid_q;
    logic [NUM_WAY-1:0]         valid_d;

    logic                       accept;
    logic                       way_in_range;
    age_op_e                    op;
    logic                       hit_en;
    logic                       fill_en;
    logic                       inv_en;
    logic [NUM_WAY-1:0]         clear_vec;
    logic [NUM_WAY-1:0]         inc_vec;

    // Handshake is purely a function of FSM state and the flush request.
    assign access_ready_out = (state_q == AGE_STATE_IDLE) && !flush_in;
    assign busy_out         = (state_q == AGE_STATE_FLUSH);
    assign accept           = access_valid_in && access_ready_out;

    // Out-of-range ways and the reserved op complete the handshake but change nothing.
    assign way_in_range = ({1'b0, access_way_in} < (WAY_INDEX_WIDTH+1)'(NUM_WAY));
    assign op           = age_op_e'(access_op_in);
    assign hit_en       = accept && way_in_range && (op == AGE_OP_HIT);
    assign fill_en      = accept && way_in_range && (op == AGE_OP_FILL);
    assign inv_en       = accept && way_in_range && (op == AGE_OP_INVALIDATE);

    // Flush FSM next state and sweep pointer; flush_in during a sweep is ignored.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            AGE_STATE_IDLE: begin
                if (flush_in) begin
                    state_d = AGE_STATE_FLUSH;
                    ptr_d   = '0;
                end
            end
            AGE_STATE_FLUSH: begin
                ptr_d = ptr_q + WAY_INDEX_WIDTH'(1);
                if (ptr_q == WAY_INDEX_WIDTH'(NUM_WAY - 1)) begin
                    state_d = AGE_STATE_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = AGE_STATE_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM state and sweep pointer registers.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= AGE_STATE_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Way decode: the target way (or swept way) clears, every other way ages on hit/fill.
    always_comb begin
        clear_vec = '0;
        inc_vec   = '0;
        valid_d   = valid_q;
        for (int i = 0; i < NUM_WAY; i++) begin
            if ((state_q == AGE_STATE_FLUSH) && (ptr_q == WAY_INDEX_WIDTH'(i))) begin
                clear_vec[i] = 1'b1;
                valid_d[i]   = 1'b0;
            end
            if (hit_en || fill_en || inv_en) begin
                if (access_way_in == WAY_INDEX_WIDTH'(i)) begin
                    clear_vec[i] = 1'b1;
                    if (fill_en) begin
                        valid_d[i] = 1'b1;
                    end
                    if (inv_en) begin
                        valid_d[i] = 1'b0;
                    end
                end else if (hit_en || fill_en) begin
                    inc_vec[i] = 1'b1;
                end
            end
        end
    end

    // Valid mask register.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // One saturating counter per way; aging uses the valid bit before this cycle's update.
    for (genvar g = 0; g < NUM_WAY; g++) begin : g_way
        age_counter_cell #(
            .W(W)
        ) u_cell (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .clear_in (clear_vec[g]),
            .inc_in   (inc_vec[g]),
            .valid_in (valid_q[g]),
            .age_out  (way_age_flatted_out[g*W +: W])
        );
    end

    assign way_valid_out = valid_q;

endmodule

// File: tb/tb_way_age_updater.sv
module tb_way_age_updater;

    localparam int W = 4;
    localparam int N = 16;
    localparam int AMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           acc_vld;
    logic [1:0]     acc_op;
    logic [3:0]     acc_way;
    logic           acc_rdy;
    logic           flush;
    logic           busy;
    logic [W*N-1:0] age_flat;
    logic [N-1:0]   vld_mask;

    int  nvec = 0;
    int  nmis = 0;
    bit  chk_en = 1'b0;

    // Behavioural model: plain per-way integers and flags.
    int  m_age [N];
    bit  m_vld [N];
    bit  m_flushing;
    int  m_ptr;

    way_age_updater #(
        .SINGLE_WAY_WIDTH_IN_BITS(W),
        .NUM_WAY(N)
    ) dut (
        .clk_in              (clk),
        .reset_in            (rst_n),
        .access_valid_in     (acc_vld),
        .access_op_in        (acc_op),
        .access_way_in       (acc_way),
        .access_ready_out    (acc_rdy),
        .flush_in            (flush),
        .busy_out            (busy),
        .way_age_flatted_out (age_flat),
        .way_valid_out       (vld_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W*N-1:0] m_flat();
        logic [W*N-1:0] f;
        f = '0;
        for (int j = 0; j < N; j++) f[j*W +: W] = W'(m_age[j]);
        return f;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] m;
        for (int j = 0; j < N; j++) m[j] = m_vld[j];
        return m;
    endfunction

    function automatic int dut_age(input int way);
        return int'(age_flat[way*W +: W]);
    endfunction

    // Largest age among valid ways, as select_biggest would see it.
    function automatic int biggest_valid_age();
        int b;
        b = -1;
        for (int j = 0; j < N; j++)
            if (vld_mask[j] && dut_age(j) > b) b = dut_age(j);
        return b;
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_step();
        if (!rst_n) begin
            for (int j = 0; j < N; j++) begin m_age[j] = 0; m_vld[j] = 0; end
            m_flushing = 0;
            m_ptr = 0;
        end else if (m_flushing) begin
            m_age[m_ptr] = 0;
            m_vld[m_ptr] = 0;
            m_ptr++;
            if (m_ptr == N) m_flushing = 0;
        end else if (flush) begin
            m_flushing = 1;
            m_ptr = 0;
        end else if (acc_vld && int'(acc_way) < N) begin
            int k;
            k = int'(acc_way);
            if (acc_op == 2'b00 || acc_op == 2'b01) begin
                for (int j = 0; j < N; j++)
                    if (j != k && m_vld[j] && m_age[j] < AMAX) m_age[j]++;
                m_age[k] = 0;
                if (acc_op == 2'b01) m_vld[k] = 1;
            end else if (acc_op == 2'b10) begin
                m_age[k] = 0;
                m_vld[k] = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; acc_vld = 1'b0; acc_op = 2'b00; acc_way = 4'd0; flush = 1'b0;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [1:0] op, input logic [3:0] way, input bit f);
        rst_n = r; acc_vld = v; acc_op = op; acc_way = way; flush = f;
        @(posedge clk);
        model_step();
        #2;
        idle_inputs();
    endtask

    // Compare process: DUT outputs against the model every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ages",  age_flat, m_flat());
            chk("cyc_valid", vld_mask, m_mask());
            chk("cyc_ready", acc_rdy,  !m_flushing && !flush);
            chk("cyc_busy",  busy,     m_flushing);
        end
    end

    initial begin
        int n;
        for (int j = 0; j < N; j++) begin m_age[j] = 0; m_vld[j] = 0; end
        m_flushing = 0;
        m_ptr = 0;
        idle_inputs();
        cyc(0, 0, 2'b00, 4'd0, 0);
        cyc(0, 0, 2'b00, 4'd0, 0);
        chk_en = 1'b1;

        // Reset state.
        chk("rst_ages",  age_flat, 64'h0);
        chk("rst_valid", vld_mask, 16'h0000);
        chk("rst_ready", acc_rdy, 1'b1);
        chk("rst_busy",  busy, 1'b0);

        // FILL ways 0,1,2 back to back.
        cyc(1, 1, 2'b01, 4'd0, 0);
        cyc(1, 1, 2'b01, 4'd1, 0);
        cyc(1, 1, 2'b01, 4'd2, 0);
        chk("fill3_ages",  age_flat, 64'h012);
        chk("fill3_valid", vld_mask, 16'h0007);
        chk("fill3_biggest", biggest_valid_age(), 2);

        // HIT way 0, then HIT invalid way 5.
        cyc(1, 1, 2'b00, 4'd0, 0);
        chk("hit0_ages", age_flat, 64'h120);
        cyc(1, 1, 2'b00, 4'd5, 0);
        chk("hit5_ages",  age_flat, 64'h231);
        chk("hit5_valid", vld_mask, 16'h0007);

        // INVALIDATE way 1, then reserved op leaves everything alone.
        cyc(1, 1, 2'b10, 4'd1, 0);
        chk("inv1_ages",  age_flat, 64'h201);
        chk("inv1_valid", vld_mask, 16'h0005);
        cyc(1, 1, 2'b11, 4'd2, 0);
        chk("nop_ages",  age_flat, 64'h201);
        chk("nop_valid", vld_mask, 16'h0005);

        // Saturation from a clean state.
        cyc(0, 0, 2'b00, 4'd0, 0);
        cyc(1, 1, 2'b01, 4'd0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 2'b00, 4'd1, 0);
        chk("sat_age0", dut_age(0), 15);
        chk("sat_age1", dut_age(1), 0);

        // Fill every way, then flush together with an access.
        for (int i = 0; i < N; i++) cyc(1, 1, 2'b01, 4'(i), 0);
        chk("fillall_valid", vld_mask, 16'hffff);
        chk("fillall_age3",  dut_age(3), 12);
        rst_n = 1'b1; acc_vld = 1'b1; acc_op = 2'b01; acc_way = 4'd3; flush = 1'b1;
        #1;
        chk("flush_req_ready", acc_rdy, 1'b0);
        @(posedge clk);
        model_step();
        #2;
        idle_inputs();
        chk("flush_no_accept_age3", dut_age(3), 12);
        chk("flush_start_busy", busy, 1'b1);
        n = 1;
        while (busy && n < 40) begin
            cyc(1, 0, 2'b00, 4'd0, 0);
            if (busy) n++;
        end
        chk("flush_busy_cycles", n, 16);
        chk("flush_end_valid", vld_mask, 16'h0000);
        chk("flush_end_ages",  age_flat, 64'h0);
        chk("flush_end_ready", acc_rdy, 1'b1);

        // Reset in the middle of a sweep.
        for (int i = 0; i < N; i++) cyc(1, 1, 2'b01, 4'(i), 0);
        cyc(1, 0, 2'b00, 4'd0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 2'b00, 4'd0, 0);
        chk("midflush_busy", busy, 1'b1);
        cyc(0, 0, 2'b00, 4'd0, 0);
        chk("midrst_busy",  busy, 1'b0);
        chk("midrst_valid", vld_mask, 16'h0000);
        chk("midrst_ages",  age_flat, 64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(!($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) < 7),
                2'($urandom_range(0, 3)),
                4'($urandom_range(0, N-1)),
                ($urandom_range(0, 99) == 0));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
